// File: rtl/button_conditioner_pkg.sv
// rtl/button_conditioner_pkg.sv - shared repeat FSM encoding and counter width helpers
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'b00,
    RPT_DELAY  = 2'b01,
    RPT_REPEAT = 2'b10
  } rpt_state_t;

  // Bits needed to hold values 0..n, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_conditioner_channel.sv
// rtl/button_conditioner_channel.sv - one button: sync, debounce, edge pulses, hold-to-repeat
module btn_channel
  import button_conditioner_pkg::*;
#(
  parameter int DEB_CYCLES   = 4,
  parameter int REPEAT_DELAY = 10,
  parameter int REPEAT_RATE  = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  input  logic rpt_en,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic rpt
);

  localparam int DW = cnt_width(DEB_CYCLES);
  localparam int RW = cnt_width(max_int(REPEAT_DELAY, REPEAT_RATE));
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

  logic          sync1, s;
  logic [DW-1:0] dcnt;
  logic          accept, level_next;

  rpt_state_t    state, state_next;
  logic [RW-1:0] rcnt, rcnt_next;
  logic          rpt_next;

  assign accept     = (s != level) && (dcnt == DEB_LAST);
  assign level_next = accept ? s : level;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1         <= 1'b0;
      s             <= 1'b0;
      dcnt          <= '0;
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync1         <= btn_raw;
      s             <= sync1;
      press         <= accept & s;
      release_pulse <= accept & ~s;
      if (s == level) begin
        dcnt <= '0;
      end else if (accept) begin
        level <= s;
        dcnt  <= '0;
      end else begin
        dcnt <= dcnt + DW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RPT_IDLE;
      rcnt  <= '0;
      rpt   <= 1'b0;
    end else begin
      state <= state_next;
      rcnt  <= rcnt_next;
      rpt   <= rpt_next;
    end
  end

  // Decisions look at level_next so a release edge can never carry a repeat pulse.
  always_comb begin
    state_next = state;
    rcnt_next  = rcnt;
    rpt_next   = 1'b0;
    if (!level_next || !rpt_en) begin
      state_next = RPT_IDLE;
      rcnt_next  = '0;
    end else begin
      case (state)
        RPT_IDLE: begin
          if (!level) begin
            state_next = RPT_DELAY;
            rcnt_next  = '0;
          end
        end
        RPT_DELAY: begin
          if (rcnt == DELAY_LAST) begin
            rpt_next   = 1'b1;
            state_next = RPT_REPEAT;
            rcnt_next  = '0;
          end else begin
            rcnt_next = rcnt + RW'(1);
          end
        end
        RPT_REPEAT: begin
          if (rcnt == RATE_LAST) begin
            rpt_next  = 1'b1;
            rcnt_next = '0;
          end else begin
            rcnt_next = rcnt + RW'(1);
          end
        end
        default: begin
          state_next = RPT_IDLE;
          rcnt_next  = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - N_CH independent button channels for the calculator front end
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int N_CH         = 5,
  parameter int DEB_CYCLES   = 4,
  parameter int REPEAT_DELAY = 10,
  parameter int REPEAT_RATE  = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_raw,
  input  logic [N_CH-1:0] rpt_en,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] rpt
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    btn_channel #(
      .DEB_CYCLES  (DEB_CYCLES),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .btn_raw      (btn_raw[i]),
      .rpt_en       (rpt_en[i]),
      .level        (level[i]),
      .press        (press[i]),
      .release_pulse(release_pulse[i]),
      .rpt          (rpt[i])
    );
  end

endmodule
